// File: rtl/sram_bus_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the SRAM arbiter and the board
// SRAM pins. The slave view belongs to the arbiter. The master view belongs to
// whatever surrounds it: the pipeline stages and the SRAM device.
interface sram_bus_arbiter_if #(
    parameter int AW = 20
);
    // Instruction-fetch port
    logic           if_req_i;
    logic [31:0]    if_addr_i;
    logic [31:0]    if_rdata_o;
    logic           if_ready_o;

    // MEM-stage data port
    logic           dm_re_i;
    logic           dm_we_i;
    logic [31:0]    dm_addr_i;
    logic [3:0]     dm_wbe_n_i;
    logic [31:0]    dm_wdata_i;
    logic [31:0]    dm_rdata_o;
    logic           dm_ready_o;

    // Board SRAM pins
    logic [AW-1:0]  sram_addr_o;
    logic [31:0]    sram_wdata_o;
    logic [31:0]    sram_rdata_i;
    logic [3:0]     sram_be_n_o;
    logic           sram_ce_n_o;
    logic           sram_oe_n_o;
    logic           sram_we_n_o;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_rdata_o, if_ready_o,
        input  dm_re_i, dm_we_i, dm_addr_i, dm_wbe_n_i, dm_wdata_i,
        output dm_rdata_o, dm_ready_o,
        output sram_addr_o, sram_wdata_o, sram_be_n_o,
        output sram_ce_n_o, sram_oe_n_o, sram_we_n_o,
        input  sram_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_rdata_o, if_ready_o,
        output dm_re_i, dm_we_i, dm_addr_i, dm_wbe_n_i, dm_wdata_i,
        input  dm_rdata_o, dm_ready_o,
        input  sram_addr_o, sram_wdata_o, sram_be_n_o,
        input  sram_ce_n_o, sram_oe_n_o, sram_we_n_o,
        output sram_rdata_i
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Shares a single-port SRAM between instruction fetch and the MEM-stage data
// port. The data port has fixed priority. Each access holds the SRAM strobes
// for WAIT_CYCLES cycles. It then spends one response cycle pulsing the
// served requester's ready, with the read data registered.
module sram_bus_arbiter #(
    parameter int WAIT_CYCLES = 2,   // legal range 1..15
    parameter int AW          = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    sram_bus_arbiter_if.slave   bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic       OWNER_IF  = 1'b0;
    localparam logic       OWNER_DM  = 1'b1;

    localparam logic [3:0] CNT_LOAD  = 4'(WAIT_CYCLES - 1);

    logic [1:0]     r_state;
    logic [3:0]     r_cnt;
    logic           r_owner;
    logic           r_write;
    logic [AW-1:0]  r_addr;
    logic [31:0]    r_wdata;
    logic           r_ce_n;
    logic           r_oe_n;
    logic           r_we_n;
    logic [3:0]     r_be_n;
    logic [31:0]    r_if_rdata;
    logic [31:0]    r_dm_rdata;
    logic           r_if_ready;
    logic           r_dm_ready;

    logic           w_dm_req;
    logic           w_start;
    logic           w_start_write;
    logic           w_done;
    logic           w_unused;

    // A simultaneous read+write on the data port counts as a write.
    assign w_dm_req      = bus.dm_re_i | bus.dm_we_i;
    assign w_start       = (r_state == ST_IDLE) && (w_dm_req || bus.if_req_i);
    assign w_start_write = w_dm_req && bus.dm_we_i;
    assign w_done        = (r_state == ST_ACCESS) && (r_cnt == 4'd0);

    // These address bits fall outside the SRAM word address.
    assign w_unused = ^{bus.if_addr_i[31:AW+2], bus.if_addr_i[1:0],
                        bus.dm_addr_i[31:AW+2], bus.dm_addr_i[1:0]};

    // Sequence each access through IDLE -> ACCESS (WAIT_CYCLES) -> RESP -> IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments make every register here update from
        // the values that were present before the edge, whatever order the
        // statements appear in.
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_ACCESS;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Latch the winning request in IDLE so the SRAM sees stable values for the
    // whole access, whatever the requesters do meanwhile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= OWNER_IF;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
        end else if (r_state == ST_IDLE) begin
            if (w_dm_req) begin
                r_owner <= OWNER_DM;
                r_write <= bus.dm_we_i;
                r_addr  <= bus.dm_addr_i[AW+1:2];
                r_wdata <= bus.dm_wdata_i;
            end else if (bus.if_req_i) begin
                r_owner <= OWNER_IF;
                r_write <= 1'b0;
                r_addr  <= bus.if_addr_i[AW+1:2];
            end
        end
    end

    // Drive the SRAM strobes straight from flops: assert them on entering
    // ACCESS and release them on leaving it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ce_n <= 1'b1;
            r_oe_n <= 1'b1;
            r_we_n <= 1'b1;
            r_be_n <= 4'hF;
        end else if (w_start) begin
            r_ce_n <= 1'b0;
            r_oe_n <= w_start_write;
            r_we_n <= ~w_start_write;
            r_be_n <= w_start_write ? bus.dm_wbe_n_i : 4'h0;
        end else if (w_done) begin
            r_ce_n <= 1'b1;
            r_oe_n <= 1'b1;
            r_we_n <= 1'b1;
            r_be_n <= 4'hF;
        end
    end

    // Capture read data on the last ACCESS cycle and pulse the owner's ready
    // during RESP. The rdata registers hold their value otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            r_if_rdata <= 32'd0;
            r_dm_rdata <= 32'd0;
        end else begin
            r_if_ready <= w_done && (r_owner == OWNER_IF);
            r_dm_ready <= w_done && (r_owner == OWNER_DM);
            if (w_done && !r_write) begin
                if (r_owner == OWNER_DM) begin
                    r_dm_rdata <= bus.sram_rdata_i;
                end else begin
                    r_if_rdata <= bus.sram_rdata_i;
                end
            end
        end
    end

    assign bus.sram_addr_o  = r_addr;
    assign bus.sram_wdata_o = r_wdata;
    assign bus.sram_be_n_o  = r_be_n;
    assign bus.sram_ce_n_o  = r_ce_n;
    assign bus.sram_oe_n_o  = r_oe_n;
    assign bus.sram_we_n_o  = r_we_n;
    assign bus.if_rdata_o   = r_if_rdata;
    assign bus.if_ready_o   = r_if_ready;
    assign bus.dm_rdata_o   = r_dm_rdata;
    assign bus.dm_ready_o   = r_dm_ready;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Scoreboard bench for sram_bus_arbiter. Stimulus pushes the expected
// responses and the expected SRAM accesses into queues. Independent monitors
// pop those queues and compare them against the ready pulses and SRAM pins.
// Two further instances, built with WAIT_CYCLES=1 and WAIT_CYCLES=15, check
// strobe duration and latency at the parameter limits.
module tb_sram_bus_arbiter;

    localparam int WC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_bus_arbiter_if #(.AW(20)) bus ();

    sram_bus_arbiter #(.WAIT_CYCLES(WC), .AW(20)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit          dm;
        logic [31:0] rdata;
        int unsigned cycle;
    } resp_t;

    typedef struct {
        logic [19:0] addr;
        bit          write;
        logic [3:0]  be_n;
        logic [31:0] wdata;
    } acc_t;

    resp_t sb_q[$];
    acc_t  acc_q[$];

    // Reference model state: last captured rdata per port, last latched wdata
    logic [31:0] last_if_rdata = 32'd0;
    logic [31:0] last_dm_rdata = 32'd0;
    logic [31:0] last_wdata    = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: every ready pulse must match the head of the scoreboard.
    always @(negedge clk) begin : resp_mon
        resp_t e;
        if (rst_n && (bus.if_ready_o || bus.dm_ready_o)) begin
            check("ready_exclusive", {63'd0, bus.if_ready_o & bus.dm_ready_o}, 64'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_ready", {62'd0, bus.if_ready_o, bus.dm_ready_o}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("resp_port", {63'd0, bus.dm_ready_o}, {63'd0, e.dm});
                check("resp_cycle", 64'(cyc), 64'(e.cycle));
                check("resp_rdata", e.dm ? bus.dm_rdata_o : bus.if_rdata_o, e.rdata);
            end
        end
    end

    // Pin monitor: compares the SRAM pins every cycle and the strobe length of each access.
    int run_len = 0;
    always @(negedge clk) begin : pin_mon
        if (!rst_n) begin
            run_len <= 0;
        end else if (!bus.sram_ce_n_o) begin
            if (acc_q.size() == 0) begin
                check("unexpected_access", {63'd0, bus.sram_ce_n_o}, 64'd1);
            end else begin
                check("access_pins",
                      {bus.sram_addr_o, bus.sram_oe_n_o, bus.sram_we_n_o, bus.sram_be_n_o, bus.sram_wdata_o},
                      {acc_q[0].addr, acc_q[0].write, ~acc_q[0].write,
                       acc_q[0].write ? acc_q[0].be_n : 4'h0, acc_q[0].wdata});
            end
            run_len <= run_len + 1;
        end else begin
            check("idle_pins", {58'd0, bus.sram_oe_n_o, bus.sram_we_n_o, bus.sram_be_n_o}, 64'h3F);
            if (run_len != 0) begin
                check("strobe_len", 64'(run_len), 64'(WC));
                if (acc_q.size() != 0) void'(acc_q.pop_front());
                run_len <= 0;
            end
        end
    end

    // Extra builds at the WAIT_CYCLES limits: one fetch each, run concurrently.
    bit ext_go = 1'b0;
    for (genvar g = 0; g < 2; g++) begin : g_ext
        localparam int WCG = (g == 0) ? 1 : 15;
        sram_bus_arbiter_if #(.AW(20)) bx ();
        bit done_g = 1'b0;

        sram_bus_arbiter #(.WAIT_CYCLES(WCG), .AW(20)) u_ext (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bx)
        );

        initial begin
            int unsigned t0;
            int          oe_cnt;
            bit          seen;
            bx.if_req_i = 1'b0;  bx.if_addr_i = 32'd0;
            bx.dm_re_i = 1'b0;   bx.dm_we_i = 1'b0;   bx.dm_addr_i = 32'd0;
            bx.dm_wbe_n_i = 4'hF; bx.dm_wdata_i = 32'd0;
            bx.sram_rdata_i = 32'h1000_0000 + WCG;
            wait (ext_go);
            @(posedge clk); #1;
            t0 = cyc;
            bx.if_req_i  = 1'b1;
            bx.if_addr_i = 32'h0000_0020;
            oe_cnt = 0;
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if (!bx.sram_oe_n_o) oe_cnt++;
                if (bx.if_ready_o) begin
                    seen = 1'b1;
                    check("ext_ready_cycle", 64'(cyc), 64'(t0 + WCG + 1));
                    check("ext_rdata", bx.if_rdata_o, 32'h1000_0000 + WCG);
                end
            end
            if (!seen) check("ext_ready_timeout", {63'd0, seen}, 64'd1);
            check("ext_strobe_len", 64'(oe_cnt), 64'(WCG));
            @(posedge clk); #1;
            bx.if_req_i = 1'b0;
            done_g = 1'b1;
        end
    end

    task automatic issue_fetch(input logic [31:0] addr, input logic [31:0] rdata);
        bus.sram_rdata_i = rdata;
        bus.if_addr_i    = addr;
        bus.if_req_i     = 1'b1;
        last_if_rdata    = rdata;
        sb_q.push_back('{1'b0, rdata, cyc + WC + 1});
        acc_q.push_back('{addr[21:2], 1'b0, 4'h0, last_wdata});
    endtask

    task automatic issue_dm(input bit re, input bit we, input logic [31:0] addr,
                            input logic [3:0] wbe_n, input logic [31:0] wdata,
                            input logic [31:0] rdata);
        bus.sram_rdata_i = rdata;
        bus.dm_re_i      = re;
        bus.dm_we_i      = we;
        bus.dm_addr_i    = addr;
        bus.dm_wbe_n_i   = wbe_n;
        bus.dm_wdata_i   = wdata;
        last_wdata       = wdata;
        if (!we) last_dm_rdata = rdata;
        sb_q.push_back('{1'b1, last_dm_rdata, cyc + WC + 1});
        acc_q.push_back('{addr[21:2], we, wbe_n, wdata});
    endtask

    task automatic wait_ready(input bit dm);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = dm ? bus.dm_ready_o : bus.if_ready_o;
        end
        if (!seen) check(dm ? "dm_ready_timeout" : "if_ready_timeout", {63'd0, seen}, 64'd1);
    endtask

    task automatic drop_all();
        @(posedge clk); #1;
        bus.if_req_i = 1'b0;
        bus.dm_re_i  = 1'b0;
        bus.dm_we_i  = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_strobes"}, {57'd0, bus.sram_ce_n_o, bus.sram_oe_n_o, bus.sram_we_n_o, bus.sram_be_n_o}, 64'h7F);
        check({tag, "_ready"}, {62'd0, bus.if_ready_o, bus.dm_ready_o}, 64'd0);
        check({tag, "_addr_wdata"}, {12'd0, bus.sram_addr_o, bus.sram_wdata_o}, 64'd0);
        check({tag, "_rdata"}, {bus.if_rdata_o, bus.dm_rdata_o}, 64'd0);
    endtask

    initial begin
        bus.if_req_i = 1'b0;  bus.if_addr_i = 32'd0;
        bus.dm_re_i = 1'b0;   bus.dm_we_i = 1'b0;   bus.dm_addr_i = 32'd0;
        bus.dm_wbe_n_i = 4'hF; bus.dm_wdata_i = 32'd0; bus.sram_rdata_i = 32'd0;

        // Power-on reset
        @(negedge clk);
        check_reset_state("reset");
        #7 rst_n = 1'b1;

        // Single fetch from byte address 0x10 (word 0x4)
        @(posedge clk); #1;
        issue_fetch(32'h0000_0010, 32'h1234_5678);
        wait_ready(1'b0);
        drop_all();

        // Byte store to 0x103 (word 0x40), top byte only
        issue_dm(1'b0, 1'b1, 32'h0000_0103, 4'b0111, 32'hAB00_0000, 32'hFFFF_FFFF);
        wait_ready(1'b1);
        drop_all();

        // Data read
        issue_dm(1'b1, 1'b0, 32'h0000_0200, 4'hF, 32'h0000_0000, 32'hCAFE_F00D);
        wait_ready(1'b1);
        drop_all();

        // Simultaneous fetch and data read: data first, fetch in the next IDLE
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h0000_0044;
        issue_dm(1'b1, 1'b0, 32'h0000_0088, 4'hF, 32'h0000_0000, 32'h5A5A_A5A5);
        last_if_rdata = 32'h0F0F_1234;
        sb_q.push_back('{1'b0, 32'h0F0F_1234, cyc + 2 * WC + 3});
        acc_q.push_back('{20'h00011, 1'b0, 4'h0, 32'h0000_0000});
        wait_ready(1'b1);
        bus.sram_rdata_i = 32'h0F0F_1234;
        @(posedge clk); #1;
        bus.dm_re_i = 1'b0;
        wait_ready(1'b0);
        drop_all();

        // Read and write together are treated as a write; rdata must not change
        issue_dm(1'b1, 1'b1, 32'h0000_03FC, 4'b0000, 32'h1122_3344, 32'h9999_9999);
        wait_ready(1'b1);
        drop_all();
        repeat (4) @(posedge clk);
        #1;

        // Reset during the second ACCESS cycle of a write
        bus.dm_we_i    = 1'b1;
        bus.dm_addr_i  = 32'h0000_0500;
        bus.dm_wbe_n_i = 4'b1100;
        bus.dm_wdata_i = 32'hDEAD_BEEF;
        acc_q.push_back('{20'h00140, 1'b1, 4'b1100, 32'hDEAD_BEEF});
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_reset_state("midreset");
        acc_q.delete();
        sb_q.delete();
        last_if_rdata = 32'd0;
        last_dm_rdata = 32'd0;
        last_wdata    = 32'd0;
        bus.dm_we_i   = 1'b0;
        #9;
        check({"midreset_hold"}, {62'd0, bus.if_ready_o, bus.dm_ready_o}, 64'd0);
        #4 rst_n = 1'b1;

        // After release the FSM must be idle: a fetch completes with nominal latency
        @(posedge clk); #1;
        issue_fetch(32'h0000_0FF0, 32'h7654_3210);
        wait_ready(1'b0);
        drop_all();
        repeat (4) @(posedge clk);

        // Parameter-limit builds
        ext_go = 1'b1;
        for (int i = 0; i < 100 && !(g_ext[0].done_g && g_ext[1].done_g); i++) @(posedge clk);
        check("ext_done", {62'd0, g_ext[1].done_g, g_ext[0].done_g}, 64'd3);

        repeat (3) @(posedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        check("acc_empty", 64'(acc_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one external single-port SRAM between the instruction-fetch port and the MEM-stage data port.
- Serializes accesses through a small FSM with a parameterized number of wait-state cycles.
- Registers read data and returns a one-cycle ready pulse to the requester that was served.
- Sits between the IF/MEM stages and the board SRAM pins. It consumes the MEM stage's dm_* signals, with dm_wbe_n active-low byte enables.

Parameters:
- WAIT_CYCLES, 2, number of cycles the SRAM strobes are held per access (legal range 1..15).
- AW, 20, SRAM word-address width; the SRAM address is addr[AW+1:2].

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- if_req_i  input  1  fetch read request; held until if_ready_o.
- if_addr_i  input  32  fetch byte address; word-aligned.
- if_rdata_o  output  32  fetch read data; valid while if_ready_o=1.
- if_ready_o  output  1  one-cycle completion pulse for fetch.
- dm_re_i  input  1  data read request; held until dm_ready_o.
- dm_we_i  input  1  data write request; held until dm_ready_o.
- dm_addr_i  input  32  data byte address.
- dm_wbe_n_i  input  4  active-low byte enables for writes.
- dm_wdata_i  input  32  write data.
- dm_rdata_o  output  32  data read data; valid while dm_ready_o=1.
- dm_ready_o  output  1  one-cycle completion pulse for the data port.
- sram_addr_o  output  AW  SRAM word address.
- sram_wdata_o  output  32  SRAM write data.
- sram_rdata_i  input  32  SRAM read data.
- sram_be_n_o  output  4  SRAM byte enables, active-low.
- sram_ce_n_o  output  1  chip enable, active-low.
- sram_oe_n_o  output  1  output enable, active-low.
- sram_we_n_o  output  1  write enable, active-low.

Behaviour:
- Reset (asynchronous, immediate, including mid-access):
  - State goes to IDLE.
  - ce_n, oe_n, we_n and be_n are driven to 1.
  - if_ready_o and dm_ready_o are 0.
  - rdata registers, sram_addr_o and sram_wdata_o are 0.
- States:
  - IDLE: sample requests.
  - ACCESS: drive the SRAM for WAIT_CYCLES cycles.
  - RESP: one cycle, ready pulse asserted.
- Requests:
  - The data request is dm_re_i|dm_we_i.
  - If both dm_re_i and dm_we_i are 1, treat it as a write.
- IDLE transitions:
  - Data request pending: latch addr, wbe_n, wdata and direction, set owner=DM, go to ACCESS.
  - Otherwise, if_req_i pending: latch addr, owner=IF, go to ACCESS.
  - Otherwise stay in IDLE.
  - Fixed priority: data over fetch. The pipeline stalls IF behind MEM, so there is no starvation.
- ACCESS:
  - All SRAM outputs come from latched registers, stable for the whole access.
  - ce_n=0 throughout.
  - Read: oe_n=0, we_n=1, be_n=4'b0000.
  - Write: oe_n=1, we_n=0, be_n=latched wbe_n.
  - A 4-bit counter loads WAIT_CYCLES-1 on entry and decrements each cycle.
  - In the cycle where the counter is 0 and the access is a read, capture sram_rdata_i into the owner's rdata register.
  - Go to RESP.
- RESP:
  - All strobes are deasserted (1).
  - Exactly the owner's ready is 1; the other ready is 0.
  - The owner's rdata_o holds the captured value; for writes it keeps its previous value.
  - Go to IDLE unconditionally. The requester may still hold its request in this cycle, and it is ignored.
- Latency: a request first seen in IDLE at cycle t gives ready at t+WAIT_CYCLES+1. Occupancy is WAIT_CYCLES+2 cycles per access.
- Back-to-back:
  - A new request asserted the cycle after ready is sampled in IDLE.
  - If both ports are waiting, the data port is served first. The fetch port is then served in the following IDLE, provided no new data request is pending.
- Request changes during ACCESS are ignored because latched values are used.
- A request dropped before ready is a protocol violation. The access still completes and the ready pulse is still issued.
- rdata_o registers update only on capture.

Test Plan:
- Reset then single fetch: WAIT_CYCLES=2, if_req_i=1, if_addr_i=0x0000_0010, sram_rdata_i=0x1234_5678.
  - sram_addr_o=0x4, oe_n=0 for 2 cycles.
  - if_ready_o=1 exactly at cycle t+3 with if_rdata_o=0x1234_5678; dm_ready_o stays 0.
- Byte store: dm_we_i=1, dm_addr_i=0x0000_0103, dm_wbe_n_i=4'b0111, dm_wdata_i=0xAB00_0000.
  - we_n=0, be_n=4'b0111, sram_addr_o=0x40, sram_wdata_o=0xAB00_0000 for 2 cycles.
  - dm_ready_o pulse follows; oe_n stays 1 throughout.
- Simultaneous requests: if_req_i and dm_re_i rise in the same cycle.
  - The data read completes first (dm_ready_o at t+3).
  - Fetch is granted in the next IDLE, with if_ready_o at t+7.
- Held request after ready: requester keeps dm_re_i=1 during RESP, then deasserts.
  - Only one access and one dm_ready_o pulse occur.
- Reset mid-access: assert rst_n=0 during the 2nd ACCESS cycle of a write.
  - we_n/ce_n go to 1 asynchronously, ready stays 0.
  - After release, the FSM is in IDLE.
- WAIT_CYCLES=1 and 15 builds: verify strobe duration of 1 and 15 cycles, and ready at t+2 and t+16.
